// File: rtl/sad_best_match_if.sv
// Candidate-stream and result bundle for the SAD best-match engine.
// master drives search control and candidate columns; slave is the engine.
interface sad_best_match_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned TAG_W = 8
);
    localparam int unsigned NPIX  = ROWS * COLS;
    localparam int unsigned LVL   = $clog2(NPIX);
    localparam int unsigned SAD_W = PIX_W + LVL;

    logic                    start;
    logic [NPIX*PIX_W-1:0]   cur_blk;
    logic                    can_valid;
    logic                    can_ready;
    logic [ROWS*PIX_W-1:0]   can_col;
    logic [TAG_W-1:0]        can_tag;
    logic                    can_last;
    logic                    sad_valid;
    logic [SAD_W-1:0]        sad;
    logic [TAG_W-1:0]        sad_tag;
    logic [SAD_W-1:0]        best_sad;
    logic [TAG_W-1:0]        best_tag;
    logic                    best_found;
    logic                    done;

    modport master (
        output start, cur_blk, can_valid, can_col, can_tag, can_last,
        input  can_ready, sad_valid, sad, sad_tag, best_sad, best_tag, best_found, done
    );

    modport slave (
        input  start, cur_blk, can_valid, can_col, can_tag, can_last,
        output can_ready, sad_valid, sad, sad_tag, best_sad, best_tag, best_found, done
    );
endinterface

// File: rtl/sad_best_match.sv
// SAD motion-estimation engine: sliding ROWS x COLS candidate window scored against a captured
// block through an abs-diff stage and a registered adder tree, tracking the minimum SAD.
module sad_best_match #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned TAG_W = 8
) (
    input logic             clk,
    input logic             rst,
    sad_best_match_if.slave sad_bus
);
    localparam int unsigned NPIX   = ROWS * COLS;
    localparam int unsigned LVL    = $clog2(NPIX);
    localparam int unsigned SAD_W  = PIX_W + LVL;
    localparam int unsigned LAT    = 2 + LVL;
    localparam int unsigned NPAD   = 1 << LVL;
    localparam int unsigned FILL_W = $clog2(COLS + 1);
    localparam int unsigned CNT_W  = $clog2(LAT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_drain_cnt;
    logic [FILL_W-1:0]     r_fill, w_fill_inc;
    logic [NPIX*PIX_W-1:0] r_cur;
    logic [ROWS*PIX_W-1:0] r_win [COLS];
    logic [PIX_W-1:0]      w_ad  [NPAD];
    logic [PIX_W-1:0]      r_ad  [NPAD];
    logic [SAD_W-1:0]      r_sum [LVL][NPAD/2];
    logic [LAT-1:0]        r_vld;
    logic [TAG_W-1:0]      r_tag [LAT];
    logic [SAD_W-1:0]      r_best_sad;
    logic [TAG_W-1:0]      r_best_tag;
    logic                  r_best_found;
    logic                  w_accept, w_issue, w_drain_end;

    always_comb begin
        w_accept    = sad_bus.can_valid && (r_state == StRun) && !sad_bus.start;
        w_fill_inc  = (r_fill == FILL_W'(COLS)) ? r_fill : r_fill + 1'b1;
        w_issue     = w_accept && (w_fill_inc == FILL_W'(COLS));
        w_drain_end = (r_state == StDrain) && (r_drain_cnt == CNT_W'(LAT));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  w_state_nxt = StIdle;
            StRun:   if (w_accept && sad_bus.can_last) w_state_nxt = StDrain;
            StDrain: if (w_drain_end) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        // start restarts the search from any state
        if (sad_bus.start) w_state_nxt = StRun;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill       <= '0;
            r_cur        <= '0;
            r_best_sad   <= '1;
            r_best_tag   <= '0;
            r_best_found <= 1'b0;
        end else if (sad_bus.start) begin
            r_fill       <= '0;
            r_cur        <= sad_bus.cur_blk;
            r_best_sad   <= '1;
            r_best_tag   <= '0;
            r_best_found <= 1'b0;
        end else begin
            if (w_accept) r_fill <= w_fill_inc;
            // strict compare: ties keep the earlier tag
            if (r_vld[LAT-1] && (!r_best_found || (r_sum[LVL-1][0] < r_best_sad))) begin
                r_best_sad   <= r_sum[LVL-1][0];
                r_best_tag   <= r_tag[LAT-1];
                r_best_found <= 1'b1;
            end
        end
    end

    always_comb begin
        logic [PIX_W-1:0] w_a, w_b;
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < NPAD; i++) begin
            w_ad[i] = '0;
            if (i < NPIX) begin
                w_a     = r_win[i / ROWS][(i % ROWS) * PIX_W +: PIX_W];
                w_b     = r_cur[i * PIX_W +: PIX_W];
                w_ad[i] = (w_a > w_b) ? w_a - w_b : w_b - w_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int unsigned k = 0; k < LAT; k++) r_tag[k] <= '0;
            for (int unsigned c = 0; c < COLS; c++) r_win[c] <= '0;
            for (int unsigned i = 0; i < NPAD; i++) r_ad[i] <= '0;
            for (int unsigned l = 0; l < LVL; l++) begin
                for (int unsigned j = 0; j < NPAD / 2; j++) r_sum[l][j] <= '0;
            end
        end else begin
            r_vld <= sad_bus.start ? '0 : {r_vld[LAT-2:0], w_issue};
            r_tag[0] <= sad_bus.can_tag;
            for (int unsigned k = 1; k < LAT; k++) r_tag[k] <= r_tag[k-1];
            if (w_accept) begin
                for (int unsigned c = 0; c + 1 < COLS; c++) r_win[c] <= r_win[c+1];
                r_win[COLS-1] <= sad_bus.can_col;
            end
            for (int unsigned i = 0; i < NPAD; i++) r_ad[i] <= w_ad[i];
            for (int unsigned j = 0; j < NPAD / 2; j++) begin
                r_sum[0][j] <= SAD_W'(r_ad[2*j]) + SAD_W'(r_ad[2*j+1]);
            end
            for (int unsigned l = 1; l < LVL; l++) begin
                for (int unsigned j = 0; j < (NPAD >> (l + 1)); j++) begin
                    r_sum[l][j] <= r_sum[l-1][2*j] + r_sum[l-1][2*j+1];
                end
            end
        end
    end

    assign sad_bus.can_ready  = (r_state == StRun);
    assign sad_bus.sad_valid  = r_vld[LAT-1];
    assign sad_bus.sad        = r_sum[LVL-1][0];
    assign sad_bus.sad_tag    = r_tag[LAT-1];
    assign sad_bus.best_sad   = r_best_sad;
    assign sad_bus.best_tag   = r_best_tag;
    assign sad_bus.best_found = r_best_found;
    assign sad_bus.done       = w_drain_end && !sad_bus.start;
endmodule

// File: tb/tb_sad_best_match.sv
// Directed bench for sad_best_match: table of searches on the 4x4 default plus abort,
// mid-search reset and a padded-tree 3x5 instance.
module tb_sad_best_match;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sad_best_match_if #(.PIX_W(8), .ROWS(4), .COLS(4), .TAG_W(8)) bus ();
    sad_best_match_if #(.PIX_W(10), .ROWS(3), .COLS(5), .TAG_W(8)) bus2 ();

    sad_best_match #(.PIX_W(8), .ROWS(4), .COLS(4), .TAG_W(8)) u_dut (
        .clk(clk), .rst(rst), .sad_bus(bus)
    );
    sad_best_match #(.PIX_W(10), .ROWS(3), .COLS(5), .TAG_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .sad_bus(bus2)
    );

    typedef struct {
        logic [127:0]      cur;
        int                ncols;
        logic [7:0][31:0]  cols;
        logic [7:0][7:0]   tags;
        bit                gaps;
        int                exp_n;
        logic [3:0][11:0]  exp_sad;
        logic [3:0][7:0]   exp_tag;
        int                exp_best;
        int                exp_btag;
        bit                exp_found;
    } vec_t;

    vec_t vecs [7];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   acc_q [$];
    int   res_cyc [$];
    logic [11:0] res_sad [$];
    logic [7:0]  res_tag [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.can_valid && bus.can_ready && !bus.start) acc_q.push_back(cyc);
        if (bus.sad_valid) begin
            res_cyc.push_back(cyc);
            res_sad.push_back(bus.sad);
            res_tag.push_back(bus.sad_tag);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void mk(input int v, input logic [127:0] cur, input int n,
                               input logic [31:0] colv, input logic [7:0] tag, input int en,
                               input int es, input int eb, input int et, input bit ef);
        vecs[v].cur   = cur;
        vecs[v].ncols = n;
        for (int i = 0; i < 8; i++) begin
            vecs[v].cols[i] = colv;
            vecs[v].tags[i] = tag;
        end
        vecs[v].gaps       = 1'b0;
        vecs[v].exp_n      = en;
        vecs[v].exp_sad    = '0;
        vecs[v].exp_tag    = '0;
        vecs[v].exp_sad[0] = es[11:0];
        vecs[v].exp_tag[0] = tag;
        vecs[v].exp_best   = eb;
        vecs[v].exp_btag   = et;
        vecs[v].exp_found  = ef;
    endfunction

    function automatic longint rst_tuple();
        return {bus.can_ready, bus.sad_valid, bus.sad, bus.sad_tag, bus.best_sad,
                bus.best_tag, bus.best_found, bus.done};
    endfunction

    localparam longint RstExp = {1'b0, 1'b0, 12'd0, 8'd0, 12'hFFF, 8'd0, 1'b0, 1'b0};

    task automatic pulse_start(input logic [127:0] cur, input bit with_valid);
        bus.start     = 1'b1;
        bus.cur_blk   = cur;
        bus.can_valid = with_valid;
        bus.can_col   = '1;
        bus.can_tag   = 8'hEE;
        bus.can_last  = 1'b0;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.can_valid = 1'b0;
        acc_q.delete();
        res_cyc.delete();
        res_sad.delete();
        res_tag.delete();
    endtask

    task automatic feed(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            if (vecs[v].gaps && i > 0) begin
                bus.can_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.can_valid = 1'b1;
            bus.can_col   = vecs[v].cols[i];
            bus.can_tag   = vecs[v].tags[i];
            bus.can_last  = (i == vecs[v].ncols - 1);
            @(posedge clk); #1;
        end
        bus.can_valid = 1'b0;
        bus.can_last  = 1'b0;
    endtask

    task automatic check_vec(input int v);
        bit seen;
        int d_cyc;
        int n_done;
        seen   = 1'b0;
        d_cyc  = 0;
        n_done = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen  = 1'b1;
                d_cyc = cyc;
            end
        end
        chk($sformatf("v%0d_done_seen", v), seen, 1);
        if (seen) begin
            chk($sformatf("v%0d_done_lat", v), (acc_q.size() > 0) ? d_cyc - acc_q[$] : -1, 7);
            chk($sformatf("v%0d_best_sad", v), bus.best_sad, vecs[v].exp_best);
            chk($sformatf("v%0d_best_tag", v), bus.best_tag, vecs[v].exp_btag);
            chk($sformatf("v%0d_best_found", v), bus.best_found, vecs[v].exp_found);
        end
        chk($sformatf("v%0d_n_results", v), res_sad.size(), vecs[v].exp_n);
        for (int k = 0; k < vecs[v].exp_n; k++) begin
            if (k < res_sad.size()) begin
                chk($sformatf("v%0d_sad%0d", v, k), res_sad[k], vecs[v].exp_sad[k]);
                chk($sformatf("v%0d_tag%0d", v, k), res_tag[k], vecs[v].exp_tag[k]);
                chk($sformatf("v%0d_lat%0d", v, k),
                    (k + 3 < acc_q.size()) ? res_cyc[k] - acc_q[k+3] : -1, 6);
            end else begin
                chk($sformatf("v%0d_sad%0d_missing", v, k), -1, vecs[v].exp_sad[k]);
            end
        end
        @(negedge clk);
        if (bus.done) n_done++;
        chk($sformatf("v%0d_hold_best", v), bus.best_sad, vecs[v].exp_best);
        chk($sformatf("v%0d_idle_ready", v), bus.can_ready, 0);
        chk($sformatf("v%0d_single_done", v), n_done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int sv_k, dn_k, n_sv, n_ev;
        logic [13:0] sv_sad;
        logic [7:0]  sv_tag;

        mk(0, {16{8'h10}}, 4, 32'h10101010, 8'h35, 1, 0, 0, 8'h35, 1);
        mk(1, {16{8'hFF}}, 4, 32'h00000000, 8'h11, 1, 4080, 4080, 8'h11, 1);
        mk(2, '0, 4, 32'hFFFFFFFF, 8'h22, 1, 4080, 4080, 8'h22, 1);
        // column sums 70,10,10,10,10,10,60 give window SADs 100,40,40,90
        mk(3, '0, 7, 32'h0000000A, 8'h00, 4, 100, 40, 2, 1);
        vecs[3].cols[0] = 32'h00000046;
        vecs[3].cols[6] = 32'h0000003C;
        for (int i = 0; i < 3; i++) vecs[3].tags[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 4; i++) begin
            vecs[3].tags[i+3]    = 8'(i + 1);
            vecs[3].exp_tag[i]   = 8'(i + 1);
        end
        vecs[3].exp_sad[1] = 12'd40;
        vecs[3].exp_sad[2] = 12'd40;
        vecs[3].exp_sad[3] = 12'd90;
        vecs[4]      = vecs[3];
        vecs[4].gaps = 1'b1;
        mk(5, {16{8'h10}}, 2, 32'h10101010, 8'h55, 0, 0, 4095, 0, 0);
        // pixel i = 16*i against 0x80 everywhere: 16 * sum|8-i| = 1024
        mk(6, 128'hF0E0D0C0B0A090807060504030201000, 4, 32'h80808080, 8'h5A, 1, 1024, 1024,
           8'h5A, 1);

        rst = 1'b1;
        bus.start = 1'b0; bus.cur_blk = '0; bus.can_valid = 1'b0;
        bus.can_col = '0; bus.can_tag = '0; bus.can_last = 1'b0;
        bus2.start = 1'b0; bus2.cur_blk = '0; bus2.can_valid = 1'b0;
        bus2.can_col = '0; bus2.can_tag = '0; bus2.can_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", rst_tuple(), RstExp);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            pulse_start(vecs[v].cur, 1'b0);
            feed(v, vecs[v].ncols);
            check_vec(v);
        end

        // abort with two candidates in flight; the valid during the new start must be ignored
        pulse_start('0, 1'b0);
        feed(3, 5);
        pulse_start(vecs[0].cur, 1'b1);
        feed(0, 4);
        check_vec(0);

        // reset in the middle of a search that already has a best
        pulse_start('0, 1'b0);
        feed(3, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_found", bus.best_found, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_state", rst_tuple(), RstExp);
        n_ev = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.sad_valid || bus.done) n_ev++;
        end
        chk("post_rst_quiet", n_ev, 0);
        @(posedge clk); #1;

        // 3x5 with 10-bit pixels: 15 pixels padded to a 16-leaf tree
        bus2.start = 1'b1;
        bus2.cur_blk = '0;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus2.can_valid = 1'b1;
            bus2.can_col   = 30'h3FFFFFFF;
            bus2.can_tag   = 8'h70 + 8'(i);
            bus2.can_last  = (i == 4);
            @(posedge clk); #1;
        end
        bus2.can_valid = 1'b0;
        bus2.can_last  = 1'b0;
        sv_k = -1; dn_k = -1; n_sv = 0; sv_sad = '0; sv_tag = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus2.sad_valid) begin
                n_sv++;
                sv_k   = k;
                sv_sad = bus2.sad;
                sv_tag = bus2.sad_tag;
            end
            if (bus2.done && dn_k < 0) dn_k = k;
        end
        chk("p35_n_results", n_sv, 1);
        chk("p35_sad_lat", sv_k, 6);
        chk("p35_sad", sv_sad, 15345);
        chk("p35_tag", sv_tag, 8'h74);
        chk("p35_done_lat", dn_k, 7);
        chk("p35_best_sad", bus2.best_sad, 15345);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
